// File: rtl/hack_cu_pkg.sv
// rtl/hack_cu_pkg.sv - Hack control unit states, instruction field indices and jump resolution
package hack_cu_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        MREAD,
        EXEC,
        HALT
    } cu_state_e;

    localparam int ABIT    = 12;
    localparam int COMP_HI = 11;
    localparam int COMP_LO = 6;
    localparam int DEST_A  = 5;
    localparam int DEST_D  = 4;
    localparam int DEST_M  = 3;
    localparam int JMP_HI  = 2;
    localparam int JMP_LO  = 0;

    function automatic int opc_idx(input int iw);
        return iw - 1;
    endfunction

    function automatic logic jump_taken(input logic [2:0] jmp, input logic zr, input logic ng);
        return (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/hack_cu_wait_timer.sv
// rtl/hack_cu_wait_timer.sv - ack wait counter with timeout pulse on the last allowed wait cycle
module hack_cu_wait_timer #(
    parameter int WAIT_MAX = 15,
    parameter int TW       = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic timeout_o
);

    localparam bit            TIMEOUT_EN = (WAIT_MAX != 0);
    localparam logic [TW-1:0] LAST       = TW'(WAIT_MAX - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Fires during the WAIT_MAX-th unacknowledged cycle so the req drops at that edge.
    assign timeout_o = TIMEOUT_EN & en_i & (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hack_mc_cu.sv
// rtl/hack_mc_cu.sv - multi-cycle Hack control unit; HACK_CU_ILLEGAL_TRAP_EN enables the illegal-prefix trap
module hack_mc_cu
    import hack_cu_pkg::*;
#(
    parameter int IW       = 16,
    parameter int WAIT_MAX = 15,
    parameter int TW       = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          halt,
    output logic          imem_req,
    input  logic          imem_ack,
    input  logic [IW-1:0] instr,
    output logic          dmem_req,
    output logic          dmem_we,
    input  logic          dmem_ack,
    input  logic          alu_zr,
    input  logic          alu_ng,
    output logic [5:0]    alu_ctl,
    output logic          sel_am,
    output logic          sel_a,
    output logic          load_a,
    output logic          load_d,
    output logic          pc_inc,
    output logic          pc_load,
    output logic          halted,
    output logic          bus_err,
    output logic          illegal
);

    localparam int OPC = opc_idx(IW);

    cu_state_e     state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    logic          imem_req_q, imem_req_d;
    logic          dmem_req_q, dmem_req_d;
    logic          dmem_we_q, dmem_we_d;
    logic          bus_err_q, bus_err_d;
    logic          illegal_flag;
    logic          jmp;
    logic          in_alu;
    logic          any_ack;
    logic          wait_en;
    logic          wait_clr;
    logic          timeout;

`ifdef HACK_CU_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    logic prefix_ok;
    assign prefix_ok    = &ir_q[IW-2:13];
    assign illegal_flag = illegal_q;
`else
    logic unused_prefix;
    assign unused_prefix = ^ir_q[IW-2:13];
    assign illegal_flag  = 1'b0;
`endif

    assign jmp = jump_taken(ir_q[JMP_HI:JMP_LO], alu_zr, alu_ng);

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        imem_req_d = imem_req_q;
        dmem_req_d = dmem_req_q;
        dmem_we_d  = dmem_we_q;
        bus_err_d  = bus_err_q;
`ifdef HACK_CU_ILLEGAL_TRAP_EN
        illegal_d  = illegal_q;
`endif
        sel_a   = 1'b0;
        load_a  = 1'b0;
        load_d  = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;

        case (state_q)
            FETCH: begin
                if (halt) begin
                    imem_req_d = 1'b0;
                    state_d    = HALT;
                end else if (imem_req_q && imem_ack) begin
                    ir_d       = instr;
                    imem_req_d = 1'b0;
                    state_d    = DECODE;
                end else if (timeout) begin
                    imem_req_d = 1'b0;
                    bus_err_d  = 1'b1;
                    state_d    = HALT;
                end else begin
                    imem_req_d = 1'b1;
                end
            end

            DECODE: begin
                if (!ir_q[OPC]) begin
                    load_a     = 1'b1;
                    pc_inc     = 1'b1;
                    imem_req_d = ~halt;
                    state_d    = FETCH;
                end
`ifdef HACK_CU_ILLEGAL_TRAP_EN
                else if (!prefix_ok) begin
                    illegal_d = 1'b1;
                    state_d   = HALT;
                end
`endif
                else if (ir_q[ABIT]) begin
                    dmem_req_d = 1'b1;
                    dmem_we_d  = 1'b0;
                    state_d    = MREAD;
                end else begin
                    dmem_req_d = ir_q[DEST_M];
                    dmem_we_d  = ir_q[DEST_M];
                    state_d    = EXEC;
                end
            end

            MREAD: begin
                if (dmem_ack) begin
                    dmem_req_d = ir_q[DEST_M];
                    dmem_we_d  = ir_q[DEST_M];
                    state_d    = EXEC;
                end else if (timeout) begin
                    dmem_req_d = 1'b0;
                    bus_err_d  = 1'b1;
                    state_d    = HALT;
                end
            end

            EXEC: begin
                // Strobes wait for the write ack so memory sees the pre-update A.
                if (!ir_q[DEST_M] || dmem_ack) begin
                    sel_a      = 1'b1;
                    load_a     = ir_q[DEST_A];
                    load_d     = ir_q[DEST_D];
                    pc_load    = jmp;
                    pc_inc     = ~jmp;
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    imem_req_d = ~halt;
                    state_d    = FETCH;
                end else if (timeout) begin
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    bus_err_d  = 1'b1;
                    state_d    = HALT;
                end
            end

            HALT: begin
                if (!halt && !bus_err_q && !illegal_flag) begin
                    imem_req_d = 1'b1;
                    state_d    = FETCH;
                end
            end

            default: begin
                imem_req_d = 1'b0;
                dmem_req_d = 1'b0;
                dmem_we_d  = 1'b0;
                state_d    = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            ir_q       <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            bus_err_q  <= 1'b0;
`ifdef HACK_CU_ILLEGAL_TRAP_EN
            illegal_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            bus_err_q  <= bus_err_d;
`ifdef HACK_CU_ILLEGAL_TRAP_EN
            illegal_q  <= illegal_d;
`endif
        end
    end

    // A late halt withdraws a pending fetch immediately.
    assign imem_req = imem_req_q & ~halt;
    assign dmem_req = dmem_req_q;
    assign dmem_we  = dmem_we_q;
    assign bus_err  = bus_err_q;
    assign illegal  = illegal_flag;
    assign halted   = (state_q == HALT);
    assign in_alu   = (state_q == EXEC) || (state_q == MREAD);
    assign alu_ctl  = in_alu ? ir_q[COMP_HI:COMP_LO] : 6'b0;
    assign sel_am   = in_alu & ir_q[ABIT];

    assign any_ack  = (imem_req & imem_ack) | (dmem_req_q & dmem_ack);
    assign wait_en  = (imem_req | dmem_req_q) & ~any_ack;
    assign wait_clr = any_ack | (state_d != state_q);

    hack_cu_wait_timer #(
        .WAIT_MAX (WAIT_MAX),
        .TW       (TW)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (wait_en),
        .clr_i     (wait_clr),
        .timeout_o (timeout)
    );

endmodule

// File: tb/tb_hack_mc_cu.sv
// tb/tb_hack_mc_cu.sv - instruction-level trace model and per-cycle compare for hack_mc_cu
module tb_hack_mc_cu;

`ifdef HACK_CU_ILLEGAL_TRAP_EN
    localparam int IW = 19;
`else
    localparam int IW = 16;
`endif

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic [5:0] alu_ctl;
        logic       sel_am;
        logic       sel_a;
        logic       load_a;
        logic       load_d;
        logic       pc_inc;
        logic       pc_load;
        logic       halted;
        logic       bus_err;
        logic       illegal;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n, halt, imem_ack, dmem_ack, alu_zr, alu_ng;
    logic [IW-1:0] instr;
    logic          imem_req, dmem_req, dmem_we, sel_am, sel_a, load_a, load_d;
    logic          pc_inc, pc_load, halted, bus_err, illegal;
    logic [5:0]    alu_ctl;

    int checks = 0;
    int errors = 0;

    vec_t        expq[$];
    string       tagq[$];
    int          lit_id[$];
    logic [5:0]  lit_val[$];
    string       lit_tag[$];

    vec_t        cur, ex;
    string       extag, ltag;
    int          lid;
    logic [5:0]  lval, lact;

    always #5 clk = ~clk;

    hack_mc_cu #(.IW(IW), .WAIT_MAX(15), .TW(4)) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt),
        .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .alu_zr(alu_zr), .alu_ng(alu_ng), .alu_ctl(alu_ctl), .sel_am(sel_am),
        .sel_a(sel_a), .load_a(load_a), .load_d(load_d), .pc_inc(pc_inc),
        .pc_load(pc_load), .halted(halted), .bus_err(bus_err), .illegal(illegal)
    );

    always @(negedge clk) begin
        cur = '{imem_req, dmem_req, dmem_we, alu_ctl, sel_am, sel_a, load_a,
                load_d, pc_inc, pc_load, halted, bus_err, illegal};
        if (expq.size() != 0) begin
            ex    = expq.pop_front();
            extag = tagq.pop_front();
            checks++;
            if (cur !== ex) begin
                errors++;
                $display("FAIL %s: got %h expected %h", extag, cur, ex);
            end
        end
        while (lit_id.size() != 0) begin
            lid  = lit_id.pop_front();
            lval = lit_val.pop_front();
            ltag = lit_tag.pop_front();
            case (lid)
                0:       lact = cur.alu_ctl;
                1:       lact = {5'b0, cur.load_a};
                2:       lact = {5'b0, cur.load_d};
                3:       lact = {5'b0, cur.pc_inc};
                4:       lact = {5'b0, cur.pc_load};
                5:       lact = {5'b0, cur.sel_am};
                6:       lact = {5'b0, cur.dmem_we};
                7:       lact = {5'b0, cur.bus_err};
                8:       lact = {5'b0, cur.halted};
                9:       lact = {5'b0, cur.illegal};
                default: lact = {5'b0, cur.imem_req};
            endcase
            checks++;
            if (lact !== lval) begin
                errors++;
                $display("FAIL %s: got %h expected %h", ltag, lact, lval);
            end
        end
    end

    function automatic logic [IW-1:0] widen(input logic [15:0] h);
        logic [IW-1:0] w;
        w = '0;
        if (h[15]) begin
            w       = '1;
            w[12:0] = h[12:0];
        end else begin
            w[14:0] = h[14:0];
        end
        return w;
    endfunction

    task automatic step(input logic r, input logic h, input logic ia, input logic da,
                        input logic z, input logic n, input logic [IW-1:0] ins,
                        input vec_t e, input string t);
        @(posedge clk);
        #1;
        rst_n = r; halt = h; imem_ack = ia; dmem_ack = da;
        alu_zr = z; alu_ng = n; instr = ins;
        expq.push_back(e);
        tagq.push_back(t);
    endtask

    task automatic lit(input int id, input logic [5:0] v, input string t);
        lit_id.push_back(id);
        lit_val.push_back(v);
        lit_tag.push_back(t);
    endtask

    // Expected trace of one instruction, starting in FETCH with the request already raised.
    task automatic do_instr(input logic [15:0] h, input int fw, input int mw,
                            input logic z, input logic n, input string t);
        vec_t          e;
        logic [IW-1:0] w;
        logic          jmp;
        w = widen(h);
        for (int i = 0; i < fw; i++) begin
            e = '0; e.imem_req = 1'b1;
            step(1, 0, 0, 1, z, n, ~w, e, {t, "/fetch_wait"});
        end
        e = '0; e.imem_req = 1'b1;
        step(1, 0, 1, 1, z, n, w, e, {t, "/fetch_ack"});
        e = '0;
        if (!h[15]) begin
            e.load_a = 1'b1; e.pc_inc = 1'b1;
            step(1, 0, 0, 1, z, n, w, e, {t, "/decode_a"});
        end else begin
            step(1, 0, 0, 1, z, n, w, e, {t, "/decode_c"});
            if (h[12]) begin
                for (int i = 0; i <= mw; i++) begin
                    e = '0; e.dmem_req = 1'b1; e.alu_ctl = h[11:6]; e.sel_am = 1'b1;
                    step(1, 0, 0, (i == mw), z, n, w, e, {t, "/mread"});
                end
            end
            if (h[3]) begin
                for (int i = 0; i < mw; i++) begin
                    e = '0; e.dmem_req = 1'b1; e.dmem_we = 1'b1;
                    e.alu_ctl = h[11:6]; e.sel_am = h[12];
                    step(1, 0, 0, 0, z, n, w, e, {t, "/mwrite_wait"});
                end
            end
            jmp = (h[2] & n) | (h[1] & z) | (h[0] & ~n & ~z);
            e = '0;
            e.dmem_req = h[3]; e.dmem_we = h[3];
            e.alu_ctl = h[11:6]; e.sel_am = h[12];
            e.sel_a = 1'b1; e.load_a = h[5]; e.load_d = h[4];
            e.pc_load = jmp; e.pc_inc = ~jmp;
            step(1, 0, 0, h[3], z, n, w, e, {t, "/exec_done"});
        end
    endtask

    initial begin
        vec_t e;
        rst_n = 0; halt = 0; imem_ack = 0; dmem_ack = 0;
        alu_zr = 0; alu_ng = 0; instr = '0;

        e = '0;
        step(0, 0, 0, 0, 0, 0, '0, e, "reset");
        step(0, 0, 1, 1, 0, 0, '1, e, "reset_acks");
        step(1, 0, 1, 0, 0, 0, widen(16'hEC10), e, "boot_ack_ignored");

        do_instr(16'h0015, 2, 0, 0, 0, "a_0015");
        lit(1, 6'd1, "a_load_a"); lit(3, 6'd1, "a_pc_inc");

        do_instr(16'hEC10, 0, 0, 0, 0, "d_eq_a");
        lit(0, 6'b110000, "d_eq_a_alu_ctl"); lit(2, 6'd1, "d_eq_a_load_d");
        lit(3, 6'd1, "d_eq_a_pc_inc");

        do_instr(16'hFC10, 0, 2, 0, 0, "d_eq_m");
        lit(5, 6'd1, "d_eq_m_sel_am"); lit(2, 6'd1, "d_eq_m_load_d");

        do_instr(16'hE308, 0, 3, 0, 0, "m_eq_d");
        lit(6, 6'd1, "m_eq_d_we_at_ack"); lit(3, 6'd1, "m_eq_d_pc_inc_at_ack");
        lit(2, 6'd0, "m_eq_d_no_load_d");

        do_instr(16'hE301, 1, 0, 0, 0, "jgt_pos");
        lit(4, 6'd1, "jgt_pos_pc_load"); lit(3, 6'd0, "jgt_pos_pc_inc");
        do_instr(16'hE301, 0, 0, 1, 0, "jgt_zero");
        lit(3, 6'd1, "jgt_zero_pc_inc"); lit(4, 6'd0, "jgt_zero_pc_load");
        do_instr(16'hE304, 0, 0, 0, 1, "jlt_neg");
        do_instr(16'hE302, 0, 0, 0, 1, "jeq_neg");
        do_instr(16'hFDF8, 0, 1, 0, 0, "amd_m_plus1");
        do_instr(16'h0007, 14, 0, 0, 0, "ack_at_limit");

        e = '0;
        step(1, 1, 0, 0, 0, 0, '0, e, "halt_req");
        e.halted = 1'b1;
        step(1, 1, 0, 0, 0, 0, '0, e, "halt_hold");
        step(1, 0, 1, 1, 0, 0, '1, e, "halt_release");
        do_instr(16'h0002, 0, 0, 0, 0, "after_halt");

        e = '0; e.imem_req = 1'b1;
        step(1, 0, 1, 0, 0, 0, widen(16'hFC10), e, "mid_fetch");
        e = '0;
        step(1, 0, 0, 0, 0, 0, '0, e, "mid_decode");
        e.dmem_req = 1'b1; e.alu_ctl = 6'b110000; e.sel_am = 1'b1;
        step(1, 0, 0, 0, 0, 0, '0, e, "mid_mread");
        step(1, 0, 0, 0, 0, 0, '0, e, "mid_mread");
        e = '0;
        step(0, 0, 0, 1, 0, 0, '0, e, "reset_mid_mread");
        step(0, 0, 0, 0, 0, 0, '0, e, "reset_hold");
        step(1, 0, 0, 0, 0, 0, '0, e, "boot2");

        e = '0; e.imem_req = 1'b1;
        for (int i = 0; i < 15; i++) step(1, 0, 0, 0, 0, 0, '0, e, "timeout_wait");
        e = '0; e.halted = 1'b1; e.bus_err = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 0, '0, e, "bus_err_halt");
        lit(7, 6'd1, "bus_err_sticky"); lit(10, 6'd0, "no_req_in_halt");

        e = '0;
        step(0, 0, 0, 0, 0, 0, '0, e, "reset_clear");
        step(1, 0, 0, 0, 0, 0, '0, e, "boot3");
        do_instr(16'h1234, 0, 0, 0, 0, "a_after_reset");

`ifdef HACK_CU_ILLEGAL_TRAP_EN
        e = '0; e.imem_req = 1'b1;
        step(1, 0, 1, 0, 0, 0, 19'h40C10, e, "illegal_fetch");
        e = '0;
        step(1, 0, 0, 0, 0, 0, '0, e, "illegal_decode");
        e.halted = 1'b1; e.illegal = 1'b1;
        step(1, 0, 0, 0, 0, 0, '0, e, "illegal_halt");
        step(1, 0, 0, 0, 0, 0, '0, e, "illegal_halt");
        lit(9, 6'd1, "illegal_sticky"); lit(8, 6'd1, "illegal_halted");
`endif

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
